// File: rtl/dsp_mult_accum_pkg.sv
// Shared constants for the DSP multiply-accumulate slice: default widths,
// opmode field positions and Z-mux select encodings.
package dsp_mult_accum_pkg;

   localparam int DEF_WIDTH  = 18;
   localparam int DEF_PWIDTH = 48;
   localparam int DEF_MREG   = 1;
   localparam int DEF_PREG   = 1;

   localparam int OP_PRE_EN   = 0;
   localparam int OP_PRE_SUB  = 1;
   localparam int OP_ZSEL_LSB = 2;
   localparam int OP_ZSEL_MSB = 3;
   localparam int OP_POST_SUB = 4;
   localparam int OP_CIN_EN   = 5;

   typedef enum logic [1:0] {
      ZSEL_ZERO = 2'b00,
      ZSEL_P    = 2'b01,
      ZSEL_C    = 2'b10,
      ZSEL_RSVD = 2'b11
   } zsel_e;

endpackage

// File: rtl/dsp_mult_accum_pipe_reg.sv
// Optional pipeline register with async active-low clear and load enable.
// With EN=0 it collapses to a plain wire so a stage can be removed by parameter.
module pipe_reg_arst #(
   parameter int W  = 1,
   parameter bit EN = 1'b1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clk_en,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   generate
      if (EN) begin : g_reg
         logic [W-1:0] data_d;
         logic [W-1:0] data_q;

         always_comb begin
            data_d = data_q;
            if (clk_en) data_d = d;
         end

         always_ff @(posedge clk or negedge rst) begin
            if (!rst) data_q <= '0;
            else      data_q <= data_d;
         end

         assign q = data_q;
      end else begin : g_wire
         logic unused_ctrl;
         assign unused_ctrl = ^{clk, rst, clk_en};
         assign q = d;
      end
   endgenerate

endmodule

// File: rtl/dsp_mult_accum.sv
// Arithmetic slice: pre-adder, unsigned multiplier, Z mux and post-adder/accumulator,
// with optional M and P pipeline stages that carry their own valid bits.
module dsp_mult_accum
   import dsp_mult_accum_pkg::*;
#(
   parameter int WIDTH  = DEF_WIDTH,
   parameter int PWIDTH = DEF_PWIDTH,
   parameter int MREG   = DEF_MREG,
   parameter int PREG   = DEF_PREG
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clk_en,
   input  logic              in_valid,
   input  logic [WIDTH-1:0]  a,
   input  logic [WIDTH-1:0]  b,
   input  logic [WIDTH-1:0]  d,
   input  logic [PWIDTH-1:0] c,
   input  logic              cin,
   input  logic [5:0]        opmode,
   output logic [PWIDTH-1:0] p,
   output logic              cout,
   output logic              out_valid
);

   localparam int MW  = 2 * WIDTH;
   localparam int SW  = PWIDTH + 1;
   localparam int SMW = MW + PWIDTH + 1 + 3;

   logic [WIDTH-1:0]  bm;
   logic [MW-1:0]     mult;
   logic              ci;
   logic [SMW-1:0]    sm_in;
   logic [SMW-1:0]    sm_out;
   logic              m_valid;
   logic [MW-1:0]     m_mult;
   logic [PWIDTH-1:0] m_c;
   logic              m_ci;
   logic              m_sub;
   logic [1:0]        m_zsel;
   logic [PWIDTH-1:0] p_fb;
   logic [PWIDTH-1:0] z;
   logic [SW-1:0]     m_ext;
   logic [SW-1:0]     sum;
   logic [SW-1:0]     p_bus;

   always_comb begin
      bm = b;
      if (opmode[OP_PRE_EN]) begin
         bm = opmode[OP_PRE_SUB] ? (d - b) : (d + b);
      end
      mult = MW'(a) * MW'(bm);
      ci   = opmode[OP_CIN_EN] & cin;
   end

   assign sm_in = {mult, c, ci, opmode[OP_POST_SUB], opmode[OP_ZSEL_MSB:OP_ZSEL_LSB]};

   // Data only loads with a valid op so bubbles never disturb held operands.
   pipe_reg_arst #(.W(SMW), .EN(MREG != 0)) u_stage_m_data (
      .clk    (clk),
      .rst    (rst),
      .clk_en (clk_en & in_valid),
      .d      (sm_in),
      .q      (sm_out)
   );

   pipe_reg_arst #(.W(1), .EN(MREG != 0)) u_stage_m_valid (
      .clk    (clk),
      .rst    (rst),
      .clk_en (clk_en),
      .d      (in_valid),
      .q      (m_valid)
   );

   assign {m_mult, m_c, m_ci, m_sub, m_zsel} = sm_out;

   // Accumulator feedback only exists when there is a P register to feed back from.
   generate
      if (PREG != 0) begin : g_fb
         assign p_fb = p_bus[PWIDTH-1:0];
      end else begin : g_nofb
         assign p_fb = '0;
      end
   endgenerate

   always_comb begin
      z = '0;
      case (zsel_e'(m_zsel))
         ZSEL_P:  z = p_fb;
         ZSEL_C:  z = m_c;
         default: z = '0;
      endcase
      m_ext = {{(SW - MW){1'b0}}, m_mult};
      if (m_sub) sum = {1'b0, z} - (m_ext + SW'(m_ci));
      else       sum = {1'b0, z} + m_ext + SW'(m_ci);
   end

   pipe_reg_arst #(.W(SW), .EN(PREG != 0)) u_stage_p_data (
      .clk    (clk),
      .rst    (rst),
      .clk_en (clk_en & m_valid),
      .d      (sum),
      .q      (p_bus)
   );

   pipe_reg_arst #(.W(1), .EN(PREG != 0)) u_stage_p_valid (
      .clk    (clk),
      .rst    (rst),
      .clk_en (clk_en),
      .d      (m_valid),
      .q      (out_valid)
   );

   assign p    = p_bus[PWIDTH-1:0];
   assign cout = p_bus[PWIDTH];

endmodule
